// File: rtl/arbiter_round_robin_selector_if.sv
// Request/acknowledge and downstream-mux handshake bundle for the round-robin selector.
// The arbiter attaches through the master modport; the requester/consumer side uses slave.
interface arbiter_round_robin_selector_if #(
  parameter int INPUT_COUNT = 4,
  parameter int ADDR_WIDTH  = 2
);
  logic [INPUT_COUNT-1:0] requests;
  logic                   out_ready;
  logic                   out_valid;
  logic [ADDR_WIDTH-1:0]  selector;
  logic [INPUT_COUNT-1:0] grants;

  modport master (
    input  requests,
    input  out_ready,
    output out_valid,
    output selector,
    output grants
  );

  modport slave (
    output requests,
    output out_ready,
    input  out_valid,
    input  selector,
    input  grants
  );
endinterface

// File: rtl/arbiter_round_robin_selector.sv
// Round-robin arbiter that holds a binary mux select until the downstream consumer takes the word.
// The index that just transferred has lowest priority in the next arbitration.
module arbiter_round_robin_selector #(
  parameter int INPUT_COUNT = 4,
  parameter int ADDR_WIDTH  = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  arbiter_round_robin_selector_if.master bus
);
  localparam int IW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_INIT = ADDR_WIDTH'(INPUT_COUNT - 1);
  localparam logic [IW-1:0]         COUNT_EXT = IW'(INPUT_COUNT);

  typedef enum logic {IDLE, GRANTED} state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] selector_reg, selector_next;
  logic [ADDR_WIDTH-1:0] last_grant_reg, last_grant_next;
  logic [ADDR_WIDTH-1:0] arb_base, winner;
  logic                  transfer, any_req;

  assign transfer = (state_reg == GRANTED) && bus.out_ready;
  assign any_req  = |bus.requests;
  // A transfer this cycle makes the outgoing selector the new lowest priority immediately.
  assign arb_base = transfer ? selector_reg : last_grant_reg;

  // Scan from farthest to nearest so the index closest after arb_base wins.
  always_comb begin : arbitrate
    logic [IW-1:0] idx;
    winner = '0;
    idx    = '0;
    for (int k = INPUT_COUNT; k >= 1; k--) begin
      idx = {1'b0, arb_base} + IW'(k);
      if (idx >= COUNT_EXT) idx = idx - COUNT_EXT;
      if (bus.requests[idx[ADDR_WIDTH-1:0]]) winner = idx[ADDR_WIDTH-1:0];
    end
  end

  always_comb begin
    state_next      = state_reg;
    selector_next   = selector_reg;
    last_grant_next = last_grant_reg;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          selector_next = winner;
          state_next    = GRANTED;
        end
      end
      GRANTED: begin
        if (bus.out_ready) begin
          last_grant_next = selector_reg;
          if (any_req) selector_next = winner;
          else         state_next    = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      selector_reg   <= '0;
      last_grant_reg <= LAST_INIT;
    end else begin
      state_reg      <= state_next;
      selector_reg   <= selector_next;
      last_grant_reg <= last_grant_next;
    end
  end

  assign bus.out_valid = (state_reg == GRANTED);
  assign bus.selector  = selector_reg;

  genvar gi;
  generate
    for (gi = 0; gi < INPUT_COUNT; gi++) begin : g_grant
      assign bus.grants[gi] = transfer && (selector_reg == ADDR_WIDTH'(gi));
    end
  endgenerate
endmodule

// File: tb/tb_arbiter_round_robin_selector.sv
// Bench for the round-robin selector: a 4-input and a 3-input instance run in lockstep
// against a queue-free scan-from-last-winner reference model.
module tb_arbiter_round_robin_selector;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  arbiter_round_robin_selector_if #(.INPUT_COUNT(4), .ADDR_WIDTH(2)) bus4 ();
  arbiter_round_robin_selector_if #(.INPUT_COUNT(3), .ADDR_WIDTH(2)) bus3 ();

  arbiter_round_robin_selector #(.INPUT_COUNT(4), .ADDR_WIDTH(2)) dut4 (
    .clock(clock), .reset(reset), .bus(bus4.master));
  arbiter_round_robin_selector #(.INPUT_COUNT(3), .ADDR_WIDTH(2)) dut3 (
    .clock(clock), .reset(reset), .bus(bus3.master));

  int total_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  // Reference model state per instance: 0 -> 4 inputs, 1 -> 3 inputs.
  int n_of[2] = '{4, 3};
  int m_valid[2];
  int m_sel[2];
  int m_last[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // First active requester after 'last', wrapping modulo n.
  function automatic int pick(input int req, input int last, input int n);
    for (int k = 1; k <= n; k++) begin
      int i;
      i = (last + k) % n;
      if (((req >> i) & 1) == 1) return i;
    end
    return -1;
  endfunction

  function automatic int exp_grants(input int u, input int rdy);
    return (m_valid[u] == 1 && rdy == 1) ? (1 << m_sel[u]) : 0;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_valid[u] = 0;
      m_sel[u]   = 0;
      m_last[u]  = n_of[u] - 1;
    end
  endtask

  task automatic model_edge(input int u, input int req, input int rdy);
    if (m_valid[u] == 0) begin
      if (req != 0) begin
        m_sel[u]   = pick(req, m_last[u], n_of[u]);
        m_valid[u] = 1;
      end
    end else if (rdy == 1) begin
      m_last[u] = m_sel[u];
      if (req != 0) m_sel[u] = pick(req, m_last[u], n_of[u]);
      else          m_valid[u] = 0;
    end
  endtask

  task automatic step(input logic [3:0] r4, input logic rd4, input logic [2:0] r3, input logic rd3);
    bus4.requests  = r4;
    bus4.out_ready = rd4;
    bus3.requests  = r3;
    bus3.out_ready = rd3;
    #1;
    check("grants4", 32'(bus4.grants), 32'(exp_grants(0, int'(rd4))));
    check("grants3", 32'(bus3.grants), 32'(exp_grants(1, int'(rd3))));
    model_edge(0, int'(r4), int'(rd4));
    model_edge(1, int'(r3), int'(rd3));
    @(posedge clock);
    #1;
    check("valid4", 32'(bus4.out_valid), 32'(m_valid[0]));
    check("sel4",   32'(bus4.selector),  32'(m_sel[0]));
    check("valid3", 32'(bus3.out_valid), 32'(m_valid[1]));
    check("sel3",   32'(bus3.selector),  32'(m_sel[1]));
    $display("step r4=%b rd4=%b sel4=%0d v4=%0d | r3=%b rd3=%b sel3=%0d v3=%0d",
             r4, rd4, bus4.selector, bus4.out_valid, r3, rd3, bus3.selector, bus3.out_valid);
  endtask

  // Asynchronous reset: outputs must clear without waiting for a clock edge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_valid4",  32'(bus4.out_valid), 32'(0));
    check("rst_sel4",    32'(bus4.selector),  32'(0));
    check("rst_grants4", 32'(bus4.grants),    32'(0));
    check("rst_valid3",  32'(bus3.out_valid), 32'(0));
    check("rst_sel3",    32'(bus3.selector),  32'(0));
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    $display("reset released t=%0t", $time);
  endtask

  initial begin
    bus4.requests  = '0;
    bus4.out_ready = 1'b0;
    bus3.requests  = '0;
    bus3.out_ready = 1'b0;
    model_reset();
    #3;
    do_reset();

    // Single requester, then back to idle.
    step(4'b0001, 1'b1, 3'b000, 1'b0);
    step(4'b0000, 1'b1, 3'b000, 1'b0);
    step(4'b0000, 1'b1, 3'b000, 1'b0);

    // Full rotation on both widths, including the 3-input wrap.
    do_reset();
    for (int i = 0; i < 6; i++) step(4'b1111, 1'b1, 3'b111, 1'b1);

    // Stall holds the selection regardless of request changes.
    do_reset();
    step(4'b0110, 1'b0, 3'b110, 1'b0);
    for (int i = 0; i < 5; i++) step((i % 2 == 0) ? 4'b0110 : 4'b1001, 1'b0, 3'b011, 1'b0);
    step(4'b0110, 1'b1, 3'b110, 1'b1);
    step(4'b0110, 1'b1, 3'b110, 1'b1);

    // Wrap from last_grant=3 to 0, then 3 wins after 0 transfers.
    do_reset();
    for (int i = 0; i < 3; i++) step(4'b1001, 1'b1, 3'b101, 1'b1);

    // Reset while holding selector=2 drops the grant.
    do_reset();
    step(4'b0100, 1'b0, 3'b100, 1'b0);
    step(4'b0100, 1'b0, 3'b100, 1'b0);
    #2;
    do_reset();
    for (int i = 0; i < 3; i++) step(4'b1111, 1'b1, 3'b111, 1'b1);

    // Randomized traffic, including requests dropped while selected.
    for (int i = 0; i < 300; i++) begin
      logic [3:0] r4;
      logic [2:0] r3;
      r4 = 4'($urandom_range(0, 15));
      r3 = 3'($urandom_range(0, 7));
      step(r4, 1'($urandom_range(0, 3) != 0), r3, 1'($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
